// File: rtl/maindec_pipe_if.sv
// D-stage decode inputs and E-stage control outputs of the main decoder.
// master drives D-stage signals; slave is the decoder.
interface maindec_pipe_if;
    logic [6:0] op;
    logic       validD;
    logic       stall_i;
    logic       flush_i;
    logic [1:0] ImmSrcD;
    logic       RegWriteE;
    logic       ALUSrcE;
    logic       MemWriteE;
    logic [1:0] ResultSrcE;
    logic       BranchE;
    logic [1:0] ALUOpE;
    logic       JumpE;
    logic       FPE;
    logic       FPlwE;
    logic       FPswE;
    logic       validE;
    logic       illegalE;
    logic       fp_busy;

    modport master (
        output op, validD, stall_i, flush_i,
        input  ImmSrcD, RegWriteE, ALUSrcE, MemWriteE,
        input  ResultSrcE, BranchE, ALUOpE, JumpE,
        input  FPE, FPlwE, FPswE, validE, illegalE, fp_busy
    );

    modport slave (
        input  op, validD, stall_i, flush_i,
        output ImmSrcD, RegWriteE, ALUSrcE, MemWriteE,
        output ResultSrcE, BranchE, ALUOpE, JumpE,
        output FPE, FPlwE, FPswE, validE, illegalE, fp_busy
    );
endinterface

// File: rtl/maindec_pipe.sv
// Main decoder: D-stage opcode decode, D->E control register,
// and a small FSM that holds E for multi-cycle FP R-type ops.
module maindec_pipe #(
    parameter bit FP_EN  = 1'b1,
    parameter int FP_LAT = 4,
    parameter int CNT_W  = $clog2(FP_LAT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    maindec_pipe_if.slave   bus
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       fp;
        logic       fp_lw;
        logic       fp_sw;
        logic       valid;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit MULTI = (FP_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_START =
        CNT_W'(MULTI ? FP_LAT - 2 : 0);

    logic is_lw, is_flw, is_sw, is_fsw, is_r;
    logic is_fpr, is_beq, is_ialu, is_jal, is_zero;

    assign is_lw   = (bus.op == 7'b0000011);
    assign is_flw  = (bus.op == 7'b0000111) && FP_EN;
    assign is_sw   = (bus.op == 7'b0100011);
    assign is_fsw  = (bus.op == 7'b0100111) && FP_EN;
    assign is_r    = (bus.op == 7'b0110011);
    assign is_fpr  = (bus.op == 7'b1010011) && FP_EN;
    assign is_beq  = (bus.op == 7'b1100011);
    assign is_ialu = (bus.op == 7'b0010011);
    assign is_jal  = (bus.op == 7'b1101111);
    assign is_zero = (bus.op == 7'b0000000);

    ctrl_t tab;
    ctrl_t dec;

    // Table is op-only so ImmSrcD does not depend on validD.
    always_comb begin
        tab = '0;
        unique case (1'b1)
            is_lw, is_flw: begin
                tab.reg_write  = 1'b1;
                tab.alu_src    = 1'b1;
                tab.result_src = 2'b01;
                tab.fp         = is_flw;
                tab.fp_lw      = is_flw;
            end
            is_sw, is_fsw: begin
                tab.imm_src   = 2'b01;
                tab.alu_src   = 1'b1;
                tab.mem_write = 1'b1;
                tab.fp        = is_fsw;
                tab.fp_sw     = is_fsw;
            end
            is_r: begin
                tab.reg_write = 1'b1;
                tab.alu_op    = 2'b10;
            end
            is_fpr: begin
                tab.reg_write = 1'b1;
                tab.fp        = 1'b1;
            end
            is_beq: begin
                tab.imm_src = 2'b10;
                tab.branch  = 1'b1;
                tab.alu_op  = 2'b01;
            end
            is_ialu: begin
                tab.reg_write = 1'b1;
                tab.alu_src   = 1'b1;
                tab.alu_op    = 2'b10;
            end
            is_jal: begin
                tab.reg_write  = 1'b1;
                tab.imm_src    = 2'b11;
                tab.result_src = 2'b10;
                tab.jump       = 1'b1;
            end
            is_zero: ;
            default: tab.illegal = 1'b1;
        endcase
        tab.valid = ~is_zero & ~tab.illegal;
    end

    always_comb begin
        dec = '0;
        if (bus.validD) dec = tab;
    end

    assign bus.ImmSrcD = tab.imm_src;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            e_q, e_d;
    logic             busy, hold, start;

    assign busy  = (state_q == BUSY);
    assign hold  = bus.stall_i | busy;
    assign start = ~hold & bus.validD & is_fpr & MULTI;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        if (bus.flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            e_d     = '0;
        end else begin
            if (!hold) e_d = dec;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = BUSY;
                        cnt_d   = CNT_START;
                    end
                end
                BUSY: begin
                    if (!bus.stall_i) begin
                        if (cnt_q == '0) state_d = IDLE;
                        else cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
        end
    end

    assign bus.RegWriteE  = e_q.reg_write;
    assign bus.ALUSrcE    = e_q.alu_src;
    assign bus.MemWriteE  = e_q.mem_write;
    assign bus.ResultSrcE = e_q.result_src;
    assign bus.BranchE    = e_q.branch;
    assign bus.ALUOpE     = e_q.alu_op;
    assign bus.JumpE      = e_q.jump;
    assign bus.FPE        = e_q.fp;
    assign bus.FPlwE      = e_q.fp_lw;
    assign bus.FPswE      = e_q.fp_sw;
    assign bus.validE     = e_q.valid;
    assign bus.illegalE   = e_q.illegal;
    assign bus.fp_busy    = busy;

    logic unused_imm;
    assign unused_imm = ^e_q.imm_src;

endmodule

// File: tb/tb_maindec_pipe.sv
// Directed bench for maindec_pipe: FP-enabled instance u0 (FP_LAT=4)
// and FP-disabled instance u1 sharing the same D-stage stimulus.
module tb_maindec_pipe;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_FLW = 7'b0000111;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_FPR = 7'b1010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    maindec_pipe_if if0 ();
    maindec_pipe_if if1 ();

    assign if1.op      = if0.op;
    assign if1.validD  = if0.validD;
    assign if1.stall_i = if0.stall_i;
    assign if1.flush_i = if0.flush_i;

    maindec_pipe #(.FP_EN(1'b1), .FP_LAT(4)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    maindec_pipe #(.FP_EN(1'b0), .FP_LAT(4)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        ncmp++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        if0.op      = OP_LW;
        if0.validD  = 1'b1;
        if0.stall_i = 1'b0;
        if0.flush_i = 1'b0;
        tick();
        tick();
        chk("rst_regw", int'(if0.RegWriteE), 0);
        chk("rst_alusrc", int'(if0.ALUSrcE), 0);
        chk("rst_res", int'(if0.ResultSrcE), 0);
        chk("rst_valid", int'(if0.validE), 0);
        chk("rst_busy", int'(if0.fp_busy), 0);

        reset = 1'b0;
        #1;
        chk("lw_imm", int'(if0.ImmSrcD), 0);
        tick();
        chk("lw_regw", int'(if0.RegWriteE), 1);
        chk("lw_alusrc", int'(if0.ALUSrcE), 1);
        chk("lw_res", int'(if0.ResultSrcE), 1);
        chk("lw_memw", int'(if0.MemWriteE), 0);
        chk("lw_valid", int'(if0.validE), 1);

        if0.op = OP_SW;
        #1;
        chk("sw_imm", int'(if0.ImmSrcD), 1);
        tick();
        chk("sw_memw", int'(if0.MemWriteE), 1);
        chk("sw_regw", int'(if0.RegWriteE), 0);

        if0.op = OP_BEQ;
        #1;
        chk("beq_imm", int'(if0.ImmSrcD), 2);
        tick();
        chk("beq_br", int'(if0.BranchE), 1);
        chk("beq_aluop", int'(if0.ALUOpE), 1);

        // FP R-type occupies E for 4 cycles, then jal follows
        if0.op = OP_FPR;
        tick();
        chk("fpr_fpe1", int'(if0.FPE), 1);
        chk("fpr_busy1", int'(if0.fp_busy), 1);
        if0.op = OP_JAL;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("fpr_fpe", int'(if0.FPE), 1);
            chk("fpr_busy", int'(if0.fp_busy), (k < 4) ? 1 : 0);
            chk("fpr_jmp", int'(if0.JumpE), 0);
        end
        tick();
        chk("jal_jmp", int'(if0.JumpE), 1);
        chk("jal_res", int'(if0.ResultSrcE), 2);
        chk("jal_fpe", int'(if0.FPE), 0);

        // flush on the 2nd busy cycle
        if0.op = OP_FPR;
        tick();
        chk("fl_busy1", int'(if0.fp_busy), 1);
        if0.op = OP_LW;
        tick();
        chk("fl_busy2", int'(if0.fp_busy), 1);
        if0.flush_i = 1'b1;
        tick();
        chk("fl_fpe", int'(if0.FPE), 0);
        chk("fl_regw", int'(if0.RegWriteE), 0);
        chk("fl_valid", int'(if0.validE), 0);
        chk("fl_busy", int'(if0.fp_busy), 0);
        if0.flush_i = 1'b0;
        tick();
        chk("fl_lw_res", int'(if0.ResultSrcE), 1);
        chk("fl_lw_regw", int'(if0.RegWriteE), 1);

        // stall freezes the counter
        if0.op = OP_FPR;
        tick();
        if0.op = OP_LW;
        if0.stall_i = 1'b1;
        tick();
        tick();
        chk("st_busy", int'(if0.fp_busy), 1);
        chk("st_fpe", int'(if0.FPE), 1);
        if0.stall_i = 1'b0;
        tick();
        tick();
        chk("st_busy2", int'(if0.fp_busy), 1);
        tick();
        chk("st_idle", int'(if0.fp_busy), 0);
        chk("st_fpe2", int'(if0.FPE), 1);
        tick();
        chk("st_lw", int'(if0.ResultSrcE), 1);

        // reset mid-sequence
        if0.op = OP_FPR;
        tick();
        reset = 1'b1;
        tick();
        chk("rm_busy", int'(if0.fp_busy), 0);
        chk("rm_fpe", int'(if0.FPE), 0);
        reset = 1'b0;

        // illegal opcode, then no valid instruction
        if0.op = OP_BAD;
        tick();
        chk("ill_flag", int'(if0.illegalE), 1);
        chk("ill_regw", int'(if0.RegWriteE), 0);
        chk("ill_memw", int'(if0.MemWriteE), 0);
        if0.validD = 1'b0;
        tick();
        chk("nv_valid", int'(if0.validE), 0);
        chk("nv_ill", int'(if0.illegalE), 0);

        // flw: legal on u0, illegal on u1
        if0.validD = 1'b1;
        if0.op = OP_FLW;
        tick();
        chk("flw_ill1", int'(if1.illegalE), 1);
        chk("flw_fpe1", int'(if1.FPE), 0);
        chk("flw_regw1", int'(if1.RegWriteE), 0);
        chk("flw_fplw0", int'(if0.FPlwE), 1);
        chk("flw_regw0", int'(if0.RegWriteE), 1);
        chk("flw_ill0", int'(if0.illegalE), 0);

        // stall holds E with beq in D
        if0.op = OP_BEQ;
        if0.stall_i = 1'b1;
        tick();
        chk("sh_br0", int'(if0.BranchE), 0);
        chk("sh_fplw0", int'(if0.FPlwE), 1);
        chk("sh_ill1", int'(if1.illegalE), 1);
        chk("sh_br1", int'(if1.BranchE), 0);
        if0.stall_i = 1'b0;
        tick();
        chk("sh_br0b", int'(if0.BranchE), 1);
        chk("sh_br1b", int'(if1.BranchE), 1);

        // flush beats stall on the same edge
        if0.stall_i = 1'b1;
        if0.flush_i = 1'b1;
        tick();
        chk("sf_valid", int'(if0.validE), 0);
        chk("sf_br", int'(if0.BranchE), 0);
        if0.stall_i = 1'b0;
        if0.flush_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
